// File: rtl/mv_field_scanner.sv
`timescale 1ns/1ps
// Raster-order motion-vector field walker feeding the block reconstructor; optional MV_ZERO_SKIP_EN drops (0,0) entries.
// Latency: Vector_sig rises 3 edges after Nxt_block_sig is sampled high in REQ (one memory read per block).
// Backpressure: waits in REQ for Nxt_block_sig=1 and holds a vector in PRESENT until Nxt_block_sig drops.
module mv_field_scanner #(
    parameter int              AW        = 16,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    height,
    input  logic [7:0]    width,
    input  logic          Nxt_block_sig,
    output logic          mvf_rd,
    output logic [AW-1:0] mvf_addr,
    input  logic [7:0]    mvf_data_x,
    input  logic [7:0]    mvf_data_y,
    output logic          Vector_sig,
    output logic [7:0]    mv_x,
    output logic [7:0]    mv_y,
    output logic [7:0]    addr_x,
    output logic [7:0]    addr_y,
    output logic          MVF_complete_sig
);

    typedef enum logic [2:0] {IDLE, REQ, RD, CAP, PRESENT, ADV, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      w_q, w_d, h_q, h_d;
    logic [7:0]      cx_q, cx_d, cy_q, cy_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [7:0]      mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [7:0]      addr_x_q, addr_x_d, addr_y_q, addr_y_d;
    logic            vector_q, vector_d;
    logic            skip_q, skip_d;
    logic            zero_entry;

`ifdef MV_ZERO_SKIP_EN
    assign zero_entry = (mvf_data_x == 8'd0) && (mvf_data_y == 8'd0);
`else
    assign zero_entry = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        h_d      = h_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        idx_d    = idx_q;
        mv_x_d   = mv_x_q;
        mv_y_d   = mv_y_q;
        addr_x_d = addr_x_q;
        addr_y_d = addr_y_q;
        vector_d = vector_q;
        skip_d   = skip_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    w_d    = width;
                    h_d    = height;
                    cx_d   = 8'd1;
                    cy_d   = 8'd1;
                    idx_d  = BASE_ADDR;
                    skip_d = 1'b0;
                    state_d = (width == 8'd0 || height == 8'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                // After a skipped entry the consumer is still waiting, so no fresh request is needed.
                if (!enable)                          state_d = IDLE;
                else if (Nxt_block_sig || skip_q)     state_d = RD;
            end
            RD: begin
                skip_d  = 1'b0;
                state_d = enable ? CAP : IDLE;
            end
            CAP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (zero_entry) begin
                    skip_d  = 1'b1;
                    state_d = ADV;
                end else begin
                    mv_x_d   = mvf_data_x;
                    mv_y_d   = mvf_data_y;
                    addr_x_d = cx_q;
                    addr_y_d = cy_q;
                    vector_d = 1'b1;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (!enable) begin
                    vector_d = 1'b0;
                    state_d  = IDLE;
                end else if (!Nxt_block_sig) begin
                    vector_d = 1'b0;
                    state_d  = ADV;
                end
            end
            ADV: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cx_q == w_q && cy_q == h_q) begin
                    state_d = DONE;
                end else begin
                    // idx tracks BASE_ADDR + (cy-1)*width + (cx-1) without a multiplier.
                    idx_d = idx_q + 1'b1;
                    if (cx_q == w_q) begin
                        cx_d = 8'd1;
                        cy_d = cy_q + 8'd1;
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                    state_d = REQ;
                end
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            w_q      <= '0;
            h_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            idx_q    <= '0;
            mv_x_q   <= '0;
            mv_y_q   <= '0;
            addr_x_q <= '0;
            addr_y_q <= '0;
            vector_q <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            h_q      <= h_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            idx_q    <= idx_d;
            mv_x_q   <= mv_x_d;
            mv_y_q   <= mv_y_d;
            addr_x_q <= addr_x_d;
            addr_y_q <= addr_y_d;
            vector_q <= vector_d;
            skip_q   <= skip_d;
        end
    end

    assign mvf_rd           = (state_q == RD);
    assign mvf_addr         = (state_q == RD) ? idx_q : '0;
    assign Vector_sig       = vector_q;
    assign mv_x             = mv_x_q;
    assign mv_y             = mv_y_q;
    assign addr_x           = addr_x_q;
    assign addr_y           = addr_y_q;
    assign MVF_complete_sig = (state_q == DONE);

endmodule

// File: tb/tb_mv_field_scanner.sv
`timescale 1ns/1ps
// Bench for mv_field_scanner: table of frame scans plus hand-written stall, reset, abort and empty-frame sequences.
module tb_mv_field_scanner;

    localparam int            AW   = 16;
    localparam logic [AW-1:0] BASE = 16'h0100;
`ifdef MV_ZERO_SKIP_EN
    localparam int ZS_VEC = 1;
`else
    localparam int ZS_VEC = 3;
`endif

    logic          CLK;
    logic          reset;
    logic          enable;
    logic [7:0]    height, width;
    logic          Nxt_block_sig;
    logic          mvf_rd;
    logic [AW-1:0] mvf_addr;
    logic [7:0]    mvf_data_x, mvf_data_y;
    logic          Vector_sig;
    logic [7:0]    mv_x, mv_y, addr_x, addr_y;
    logic          MVF_complete_sig;

    mv_field_scanner #(.AW(AW), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .height(height), .width(width),
        .Nxt_block_sig(Nxt_block_sig), .mvf_rd(mvf_rd), .mvf_addr(mvf_addr),
        .mvf_data_x(mvf_data_x), .mvf_data_y(mvf_data_y), .Vector_sig(Vector_sig),
        .mv_x(mv_x), .mv_y(mv_y), .addr_x(addr_x), .addr_y(addr_y),
        .MVF_complete_sig(MVF_complete_sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: data valid the cycle after the read strobe.
    logic [7:0]    mem_x [256];
    logic [7:0]    mem_y [256];
    logic [AW-1:0] mem_off;
    assign mem_off = mvf_addr - BASE;
    always @(posedge CLK) begin
        if (mvf_rd) begin
            mvf_data_x <= mem_x[mem_off[7:0]];
            mvf_data_y <= mem_y[mem_off[7:0]];
        end
    end

    typedef struct packed {logic [7:0] x; logic [7:0] y; logic [7:0] ax; logic [7:0] ay;} vec_t;
    typedef struct {int w; int h; int pat; int exp_vec; int exp_rd;} case_t;

    vec_t          exp_vec_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_rd     = 0;
    int            n_vec    = 0;
    bit            vec_prev = 1'b0;
    vec_t          mon_v;
    logic [AW-1:0] mon_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fill_mem(input int pat);
        for (int i = 0; i < 256; i++) begin
            mem_x[i] = 8'(2 * i + 1);
            mem_y[i] = 8'(2 * i + 2);
        end
        if (pat == 1) begin
            mem_x[0] = 8'd0; mem_y[0] = 8'd0;
            mem_x[1] = 8'd2; mem_y[1] = 8'd0;
            mem_x[2] = 8'd0; mem_y[2] = 8'd0;
        end
    endtask

    // Reference model: expected read addresses and presented vectors for a whole frame.
    task automatic push_frame(input int w, input int h);
        logic [7:0] k;
        bit z;
        for (int cy = 1; cy <= h; cy++) begin
            for (int cx = 1; cx <= w; cx++) begin
                k = 8'((cy - 1) * w + (cx - 1));
                exp_addr_q.push_back(BASE + AW'((cy - 1) * w + (cx - 1)));
                z = 1'b0;
`ifdef MV_ZERO_SKIP_EN
                z = (mem_x[k] == 8'd0) && (mem_y[k] == 8'd0);
`endif
                if (!z) exp_vec_q.push_back('{x: mem_x[k], y: mem_y[k], ax: 8'(cx), ay: 8'(cy)});
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; Nxt_block_sig = 1'b0;
        width = 8'd0; height = 8'd0;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        exp_addr_q.delete();
        exp_vec_q.delete();
        n_rd = 0; n_vec = 0;
        @(negedge CLK);
    endtask

    // Consumer: request while idle, release once a vector is seen.
    task automatic run_scan(input int max_cyc, output bit to);
        to = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge CLK);
            if (MVF_complete_sig) begin
                to = 1'b0;
                break;
            end
            Nxt_block_sig = Vector_sig ? 1'b0 : 1'b1;
        end
    endtask

    task automatic wait_vector(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge CLK);
            if (Vector_sig) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge CLK);
            if (!reset) begin
                if (mvf_rd) begin
                    n_rd++;
                    chk("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                    if (exp_addr_q.size() != 0) begin
                        mon_a = exp_addr_q.pop_front();
                        chk("mvf_addr", 32'(mvf_addr), 32'(mon_a));
                    end
                end
                if (Vector_sig && !vec_prev) begin
                    n_vec++;
                    chk("vec_expected", 32'(exp_vec_q.size() != 0), 32'd1);
                    if (exp_vec_q.size() != 0) begin
                        mon_v = exp_vec_q.pop_front();
                        chk("vector", {mv_x, mv_y, addr_x, addr_y}, mon_v);
                    end
                end
            end
            vec_prev = Vector_sig;
        end
    end

    case_t tbl [6];
    bit    to;
    int    rd0, edges;

    initial begin
        tbl[0] = '{2, 2, 0, 4, 4};
        tbl[1] = '{3, 1, 0, 3, 3};
        tbl[2] = '{1, 3, 0, 3, 3};
        tbl[3] = '{0, 5, 0, 0, 0};
        tbl[4] = '{4, 0, 0, 0, 0};
        tbl[5] = '{3, 1, 1, ZS_VEC, 3};

        // Reset state
        do_reset();
        chk("rst_outputs", {mv_x, mv_y, addr_x, addr_y}, 32'd0);
        chk("rst_vector", 32'(Vector_sig), 32'd0);
        chk("rst_rd", {15'd0, mvf_rd, mvf_addr}, 32'd0);
        chk("rst_complete", 32'(MVF_complete_sig), 32'd0);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            fill_mem(tbl[t].pat);
            push_frame(tbl[t].w, tbl[t].h);
            width = 8'(tbl[t].w); height = 8'(tbl[t].h);
            Nxt_block_sig = 1'b1;
            enable = 1'b1;
            run_scan(2000, to);
            chk("scan_timeout", 32'(to), 32'd0);
            chk("scan_complete", 32'(MVF_complete_sig), 32'd1);
            chk("scan_vectors", 32'(n_vec), 32'(tbl[t].exp_vec));
            chk("scan_reads", 32'(n_rd), 32'(tbl[t].exp_rd));
            chk("scan_left", 32'(exp_vec_q.size() + exp_addr_q.size()), 32'd0);
            enable = 1'b0;
            @(negedge CLK);
            chk("complete_clear", 32'(MVF_complete_sig), 32'd0);
        end

        // Empty frame reaches DONE one edge after enable
        do_reset();
        width = 8'd0; height = 8'd5; Nxt_block_sig = 1'b1; enable = 1'b1;
        @(negedge CLK);
        chk("empty_done", 32'(MVF_complete_sig), 32'd1);
        repeat (3) @(negedge CLK);
        chk("empty_activity", 32'(n_rd + n_vec), 32'd0);

        // Consumer stall, then release latency
        do_reset();
        fill_mem(0);
        push_frame(2, 1);
        width = 8'd2; height = 8'd1; Nxt_block_sig = 1'b1; enable = 1'b1;
        wait_vector("stall_first_vec", 50);
        Nxt_block_sig = 1'b0;
        rd0 = n_rd;
        repeat (10) begin
            @(negedge CLK);
            chk("stall_hold", {mv_x, mv_y, addr_x, addr_y}, {mem_x[0], mem_y[0], 8'd1, 8'd1});
        end
        chk("stall_no_rd", 32'(n_rd), 32'(rd0));
        chk("stall_vec_low", 32'(Vector_sig), 32'd0);
        Nxt_block_sig = 1'b1;
        edges = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            edges++;
            if (Vector_sig) break;
        end
        chk("release_latency", 32'(edges), 32'd3);
        run_scan(200, to);
        chk("stall_complete", 32'(MVF_complete_sig), 32'd1);
        chk("stall_vectors", 32'(n_vec), 32'd2);

        // Reset while presenting, then a clean restart
        do_reset();
        fill_mem(0);
        push_frame(2, 2);
        width = 8'd2; height = 8'd2; Nxt_block_sig = 1'b1; enable = 1'b1;
        wait_vector("prst_vec", 50);
        reset = 1'b1;
        @(negedge CLK);
        chk("prst_vector", 32'(Vector_sig), 32'd0);
        chk("prst_outputs", {mv_x, mv_y, addr_x, addr_y}, 32'd0);
        chk("prst_complete", {15'd0, MVF_complete_sig, mvf_addr}, 32'd0);
        exp_addr_q.delete();
        exp_vec_q.delete();
        push_frame(2, 2);
        n_vec = 0; n_rd = 0;
        reset = 1'b0;
        run_scan(500, to);
        chk("restart_complete", 32'(MVF_complete_sig), 32'd1);
        chk("restart_vectors", 32'(n_vec), 32'd4);

        // enable dropped during the read cycle
        do_reset();
        fill_mem(0);
        push_frame(2, 1);
        width = 8'd2; height = 8'd1; Nxt_block_sig = 1'b1; enable = 1'b1;
        to = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (mvf_rd) begin
                to = 1'b0;
                break;
            end
        end
        chk("abort_rd_seen", 32'(to), 32'd0);
        enable = 1'b0;
        @(negedge CLK);
        chk("abort_state", {Vector_sig, mvf_rd, MVF_complete_sig}, 32'd0);
        repeat (5) @(negedge CLK);
        chk("abort_no_vec", 32'(n_vec), 32'd0);
        chk("abort_reads", 32'(n_rd), 32'd1);
        chk("abort_complete", 32'(MVF_complete_sig), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
